// File: rtl/uart_mem_cmd_if.sv
// Bundle of the parser's UART receive stream, memory port, transmit stream and error pulse.
// The parser side uses master; memory, UART and bench use slave.
interface uart_mem_cmd_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              err;

  modport master (
    input  s_tdata, s_tvalid, mem_rdata, m_tready,
    output s_tready, mem_addr, mem_wdata, mem_we, mem_re, m_tdata, m_tvalid, err
  );

  modport slave (
    output s_tdata, s_tvalid, mem_rdata, m_tready,
    input  s_tready, mem_addr, mem_wdata, mem_we, mem_re, m_tdata, m_tvalid, err
  );
endinterface

// File: rtl/uart_mem_cmd.sv
// UART command parser: 'W' addr data -> one memory write; 'R' addr -> memory read echoed on the
// transmit stream. Unknown commands, out-of-range addresses and inter-byte timeouts pulse err.
module uart_mem_cmd #(
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input logic             clk,
  input logic             rst,
  uart_mem_cmd_if.master  bus
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] CMD_WR  = DATA_W'(8'h57);
  localparam logic [DATA_W-1:0] CMD_RD  = DATA_W'(8'h52);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, WRITE, READ_REQ, READ_WAIT, SEND
  } state_t;

  state_t           state, state_nx;
  logic             is_wr;
  logic [CNT_W-1:0] cnt;
  logic             hs, addr_bad, is_cmd, timeout;
  logic             err_nx, ld_cmd, ld_addr, ld_data, ld_rdata;

  assign hs       = bus.s_tvalid && bus.s_tready;
  assign addr_bad = (bus.s_tdata >> ADDR_W) != '0;
  assign is_cmd   = (bus.s_tdata == CMD_WR) || (bus.s_tdata == CMD_RD);
  // An arriving byte beats the timeout on the final counter cycle.
  assign timeout  = (cnt == CNT_MAX) && !hs;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (hs && is_cmd) state_nx = GET_ADDR;
      GET_ADDR: begin
        if (hs) state_nx = addr_bad ? IDLE : (is_wr ? GET_DATA : READ_REQ);
        else if (timeout) state_nx = IDLE;
      end
      GET_DATA: begin
        if (hs) state_nx = WRITE;
        else if (timeout) state_nx = IDLE;
      end
      WRITE:     state_nx = IDLE;
      READ_REQ:  state_nx = READ_WAIT;
      READ_WAIT: state_nx = SEND;
      SEND:      if (bus.m_tready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.s_tready = (state == IDLE) || (state == GET_ADDR) || (state == GET_DATA);
    bus.mem_we   = (state == WRITE);
    bus.mem_re   = (state == READ_REQ);
    bus.m_tvalid = (state == SEND);
    ld_cmd       = (state == IDLE) && hs;
    ld_addr      = (state == GET_ADDR) && hs && !addr_bad;
    ld_data      = (state == GET_DATA) && hs;
    ld_rdata     = (state == READ_WAIT);
    err_nx       = 1'b0;
    case (state)
      IDLE:     err_nx = hs && !is_cmd;
      GET_ADDR: err_nx = (hs && addr_bad) || timeout;
      GET_DATA: err_nx = timeout;
      default:  err_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr         <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.m_tdata   <= '0;
      bus.err       <= 1'b0;
    end else begin
      bus.err <= err_nx;
      if (ld_cmd)   is_wr         <= (bus.s_tdata == CMD_WR);
      if (ld_addr)  bus.mem_addr  <= ADDR_W'(bus.s_tdata);
      if (ld_data)  bus.mem_wdata <= bus.s_tdata;
      if (ld_rdata) bus.m_tdata   <= bus.mem_rdata;
    end
  end

  // Idle-cycle counter: only meaningful while a command is partially received.
  always_ff @(posedge clk) begin
    if (rst || hs || (state != state_nx) ||
        !((state == GET_ADDR) || (state == GET_DATA)))
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_uart_mem_cmd.sv
// Directed bench for uart_mem_cmd: a command table plus hand-built latency, backpressure,
// timeout and reset sequences, against a small registered-read memory model.
module tb_uart_mem_cmd;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int TO     = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_mem_cmd_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  uart_mem_cmd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [128] = '{default: 8'h00};
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int we_cnt = 0, re_cnt = 0, err_cnt = 0, tx_cnt = 0;
  logic [7:0] we_addr = 8'h00, we_data = 8'h00, tx_data = 8'h00;
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.mem_we) begin
        we_cnt++;
        we_addr = {1'b0, bus.mem_addr};
        we_data = bus.mem_wdata;
      end
      if (bus.mem_re) re_cnt++;
      if (bus.err) err_cnt++;
      if (bus.m_tvalid && bus.m_tready) begin
        tx_cnt++;
        tx_data = bus.m_tdata;
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = b;
    while (!bus.s_tready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.s_tready) check("s_tready_wait", 32'(bus.s_tready), 32'd1);
    tick();
    bus.s_tvalid = 1'b0;
  endtask

  task automatic wait_tvalid(input string name);
    int n = 0;
    while (!bus.m_tvalid && n < 10) begin
      tick();
      n++;
    end
    check(name, 32'(bus.m_tvalid), 32'd1);
  endtask

  typedef struct {
    string      name;
    logic [7:0] b0, b1, b2;
    int         n;
    int         d_we, d_re, d_err, d_tx;
    logic [7:0] e_addr, e_wdata, e_tx;
  } vec_t;

  function automatic vec_t mk(string name, logic [7:0] b0, b1, b2, int n,
                              int d_we, d_re, d_err, d_tx,
                              logic [7:0] e_addr, e_wdata, e_tx);
    vec_t v;
    v.name = name; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.n = n;
    v.d_we = d_we; v.d_re = d_re; v.d_err = d_err; v.d_tx = d_tx;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_tx = e_tx;
    return v;
  endfunction

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s_we, s_re, s_err, s_tx, bad;
    tbl[0]  = mk("wr_05",     8'h57, 8'h05, 8'hA3, 3, 1, 0, 0, 0, 8'h05, 8'hA3, 8'h00);
    tbl[1]  = mk("rd_05",     8'h52, 8'h05, 8'h00, 2, 0, 1, 0, 1, 8'h00, 8'h00, 8'hA3);
    tbl[2]  = mk("bad_cmd",   8'h41, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    tbl[3]  = mk("bad_waddr", 8'h57, 8'h80, 8'h00, 2, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    tbl[4]  = mk("wr_7f",     8'h57, 8'h7F, 8'h3C, 3, 1, 0, 0, 0, 8'h7F, 8'h3C, 8'h00);
    tbl[5]  = mk("rd_7f",     8'h52, 8'h7F, 8'h00, 2, 0, 1, 0, 1, 8'h00, 8'h00, 8'h3C);
    tbl[6]  = mk("wr_10",     8'h57, 8'h10, 8'h5A, 3, 1, 0, 0, 0, 8'h10, 8'h5A, 8'h00);
    tbl[7]  = mk("wr_00",     8'h57, 8'h00, 8'h11, 3, 1, 0, 0, 0, 8'h00, 8'h11, 8'h00);
    tbl[8]  = mk("rd_00",     8'h52, 8'h00, 8'h00, 2, 0, 1, 0, 1, 8'h00, 8'h00, 8'h11);
    tbl[9]  = mk("rd_7f_b",   8'h52, 8'h7F, 8'h00, 2, 0, 1, 0, 1, 8'h00, 8'h00, 8'h3C);
    tbl[10] = mk("bad_raddr", 8'h52, 8'hFF, 8'h00, 2, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    tbl[11] = mk("lower_r",   8'h72, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);

    rst = 1'b1;
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = 8'h00;
    bus.m_tready = 1'b1;
    repeat (2) tick();
    check("rst_s_tready",  32'(bus.s_tready),  32'd1);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_mem_re",    32'(bus.mem_re),    32'd0);
    check("rst_m_tvalid",  32'(bus.m_tvalid),  32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_m_tdata",   32'(bus.m_tdata),   32'd0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      s_we = we_cnt; s_re = re_cnt; s_err = err_cnt; s_tx = tx_cnt;
      send_byte(tbl[i].b0);
      if (tbl[i].n > 1) send_byte(tbl[i].b1);
      if (tbl[i].n > 2) send_byte(tbl[i].b2);
      repeat (6) tick();
      check({tbl[i].name, "_we"},  32'(we_cnt - s_we),   32'(tbl[i].d_we));
      check({tbl[i].name, "_re"},  32'(re_cnt - s_re),   32'(tbl[i].d_re));
      check({tbl[i].name, "_err"}, 32'(err_cnt - s_err), 32'(tbl[i].d_err));
      check({tbl[i].name, "_tx"},  32'(tx_cnt - s_tx),   32'(tbl[i].d_tx));
      if (tbl[i].d_we != 0) begin
        check({tbl[i].name, "_waddr"}, 32'(we_addr), 32'(tbl[i].e_addr));
        check({tbl[i].name, "_wdata"}, 32'(we_data), 32'(tbl[i].e_wdata));
      end
      if (tbl[i].d_tx != 0) check({tbl[i].name, "_tdata"}, 32'(tx_data), 32'(tbl[i].e_tx));
    end

    // Exact strobe and return latencies.
    send_byte(8'h57); send_byte(8'h21); send_byte(8'h66);
    check("lat_we_pulse", 32'(bus.mem_we),    32'd1);
    check("lat_we_addr",  32'(bus.mem_addr),  32'h21);
    check("lat_we_data",  32'(bus.mem_wdata), 32'h66);
    tick();
    check("lat_we_drop",  32'(bus.mem_we),    32'd0);
    check("lat_idle_rdy", 32'(bus.s_tready),  32'd1);
    send_byte(8'h52); send_byte(8'h21);
    check("lat_re_pulse", 32'(bus.mem_re),   32'd1);
    check("lat_re_addr",  32'(bus.mem_addr), 32'h21);
    tick();
    check("lat_re_drop",  32'(bus.mem_re),   32'd0);
    check("lat_tv_early", 32'(bus.m_tvalid), 32'd0);
    tick();
    check("lat_tv",       32'(bus.m_tvalid), 32'd1);
    check("lat_tdata",    32'(bus.m_tdata),  32'h66);
    tick();
    check("lat_tv_drop",  32'(bus.m_tvalid), 32'd0);

    // Transmit backpressure, with a byte offered that must not be consumed.
    repeat (2) tick();
    s_err = err_cnt;
    bus.m_tready = 1'b0;
    send_byte(8'h52); send_byte(8'h7F);
    wait_tvalid("bp_tvalid");
    s_tx = tx_cnt;
    bad = 0;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = 8'h41;
    repeat (10) begin
      tick();
      if (!(bus.m_tvalid && bus.m_tdata == 8'h3C && !bus.s_tready)) bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b1;
    tick();
    tick();
    check("bp_tv_drop", 32'(bus.m_tvalid), 32'd0);
    repeat (3) tick();
    check("bp_tx_once", 32'(tx_cnt - s_tx),   32'd1);
    check("bp_tx_data", 32'(tx_data),         32'h3C);
    check("bp_no_err",  32'(err_cnt - s_err), 32'd0);

    // Timeout while waiting for the data byte; the pending write must be dropped.
    s_we = we_cnt; s_err = err_cnt; s_tx = tx_cnt;
    send_byte(8'h57); send_byte(8'h10);
    repeat (TO - 1) tick();
    check("to_no_err_yet", 32'(bus.err),      32'd0);
    check("to_still_rdy",  32'(bus.s_tready), 32'd1);
    tick();
    check("to_err",        32'(bus.err),      32'd1);
    tick();
    check("to_err_pulse",  32'(bus.err),      32'd0);
    send_byte(8'h52); send_byte(8'h10);
    repeat (6) tick();
    check("to_no_we",   32'(we_cnt - s_we),   32'd0);
    check("to_one_err", 32'(err_cnt - s_err), 32'd1);
    check("to_rd_tx",   32'(tx_cnt - s_tx),   32'd1);
    check("to_rd_data", 32'(tx_data),         32'h5A);

    // Bytes landing on the final counter cycle are accepted.
    s_we = we_cnt; s_err = err_cnt;
    send_byte(8'h57);
    repeat (TO - 1) tick();
    send_byte(8'h10);
    check("tb_addr_ok",  32'(bus.err),       32'd0);
    check("tb_in_data",  32'(bus.s_tready),  32'd1);
    repeat (TO - 1) tick();
    send_byte(8'h77);
    check("tb_we",       32'(bus.mem_we),    32'd1);
    check("tb_we_addr",  32'(bus.mem_addr),  32'h10);
    check("tb_we_data",  32'(bus.mem_wdata), 32'h77);
    repeat (3) tick();
    check("tb_no_err",   32'(err_cnt - s_err), 32'd0);
    check("tb_one_we",   32'(we_cnt - s_we),   32'd1);

    // Reset while a transmit byte is pending.
    s_tx = tx_cnt;
    bus.m_tready = 1'b0;
    send_byte(8'h52); send_byte(8'h10);
    wait_tvalid("rs_send_tvalid");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_tvalid", 32'(bus.m_tvalid), 32'd0);
    check("rs_tdata",  32'(bus.m_tdata),  32'd0);
    check("rs_rdy",    32'(bus.s_tready), 32'd1);
    bus.m_tready = 1'b1;
    repeat (3) tick();
    check("rs_no_tx",  32'(tx_cnt - s_tx), 32'd0);

    // Reset mid-command: following byte is a fresh (unknown) command.
    s_we = we_cnt; s_err = err_cnt;
    send_byte(8'h57); send_byte(8'h20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_addr_clr", 32'(bus.mem_addr), 32'd0);
    send_byte(8'h55);
    repeat (4) tick();
    check("rm_no_we",  32'(we_cnt - s_we),   32'd0);
    check("rm_err",    32'(err_cnt - s_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
